// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the decode-stage branch unit: funct3 codes,
// BHT counter encoding and the 2-bit saturating counter update.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_cond_eval.sv
// Combinational branch condition evaluation: XLEN-wide compares selected
// by funct3, with the two reserved encodings flagged as illegal.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            cond,
    output logic            illegal
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign eq_s  = (rs1 == rs2);
    assign lt_s  = ($signed(rs1) < $signed(rs2));
    assign ltu_s = (rs1 < rs2);

    // Select the comparison result for the requested condition
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq_s;
            F3_BNE:  cond = ~eq_s;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = ~lt_s;
            F3_BLTU: cond = ltu_s;
            F3_BGEU: cond = ~ltu_s;
            default: begin
                cond    = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Decode-stage branch unit: resolves branches/jumps, trains a bimodal BHT
// read by fetch, flags mispredictions and counts branch events.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         PC_LSB      = 2,
    parameter logic [1:0] BHT_INIT    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             d_valid,
    input  logic [XLEN-1:0]  d_pc,
    input  logic             d_pred_taken,
    input  logic [XLEN-1:0]  rs1_mod,
    input  logic [XLEN-1:0]  rs2_mod,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic             jal,
    input  logic             jalr,
    input  logic             hazard,
    input  logic             bht_flush,
    output logic             branch_taken,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t         bht_r [BHT_ENTRIES];
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    logic [IDX_W-1:0] f_idx_s;
    logic [IDX_W-1:0] d_idx_s;
    logic             act_s;
    logic             cond_s;
    logic             illegal_cond_s;
    logic             taken_s;
    logic             mispred_s;
    logic             illegal_s;
    logic             upd_s;
    logic             unused_pc_s;

    assign f_idx_s     = f_pc[PC_LSB +: IDX_W];
    assign d_idx_s     = d_pc[PC_LSB +: IDX_W];
    assign act_s       = d_valid & ~hazard;
    assign unused_pc_s = ^{f_pc, d_pc};

    branch_cond_eval #(
        .XLEN(XLEN)
    ) u_cond (
        .rs1     (rs1_mod),
        .rs2     (rs2_mod),
        .funct3  (funct3),
        .cond    (cond_s),
        .illegal (illegal_cond_s)
    );

    // Resolve the decode instruction; jalr outranks jal, which outranks branch
    always_comb begin
        taken_s   = 1'b0;
        mispred_s = 1'b0;
        illegal_s = 1'b0;
        upd_s     = 1'b0;
        if (act_s) begin
            if (jalr) begin
                taken_s   = 1'b1;
                mispred_s = 1'b1;
            end else if (jal) begin
                taken_s   = 1'b1;
                mispred_s = ~d_pred_taken;
            end else if (branch) begin
                if (illegal_cond_s) begin
                    illegal_s = 1'b1;
                end else begin
                    taken_s   = cond_s;
                    mispred_s = (cond_s != d_pred_taken);
                    upd_s     = 1'b1;
                end
            end else begin
                taken_s = 1'b0;
            end
        end else begin
            taken_s = 1'b0;
        end
    end

    // BHT training; a flush overrides a coincident update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= bht_ctr_t'(BHT_INIT);
            end
        end else if (bht_flush) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= bht_ctr_t'(BHT_INIT);
            end
        end else if (upd_s) begin
            bht_r[d_idx_s] <= sat_update(bht_r[d_idx_s], taken_s);
        end
    end

    // Wrap-around performance counters, independent of BHT flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_r      <= '0;
            mispred_cnt_r <= '0;
        end else begin
            if (upd_s) begin
                br_cnt_r <= br_cnt_r + CNT_W'(1'b1);
            end
            if (mispred_s) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign f_pred_taken = bht_r[f_idx_s][1];
    assign branch_taken = taken_s;
    assign mispredict   = mispred_s;
    assign illegal_br   = illegal_s;
    assign br_cnt       = br_cnt_r;
    assign mispred_cnt  = mispred_cnt_r;

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised branch unit for the Mini-RISC-V decode stage.
- Resolves conditional branches, jal and jalr from forwarded operands. Same comparison semantics as the existing decision logic, generalised to XLEN.
- Adds a bimodal branch history table (BHT) of 2-bit saturating counters. The fetch stage reads it for predictions; resolved branches train it.
- Flags mispredictions and keeps wrap-around performance counters.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of counters; power of two, minimum 2.
- PC_LSB, 2, lowest PC bit used for the index. Index = pc[PC_LSB +: log2(BHT_ENTRIES)].
- BHT_INIT, 2'b01, counter value after reset or flush.
- CNT_W, 32, performance counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- f_pc  input  XLEN  fetch PC to look up.
- f_pred_taken  output  1  MSB of the indexed counter; combinational from BHT state.
- d_valid  input  1  decode slot holds a valid instruction.
- d_pc  input  XLEN  PC of the decode instruction.
- d_pred_taken  input  1  prediction carried down the pipe with the instruction.
- rs1_mod  input  XLEN  forwarded rs1.
- rs2_mod  input  XLEN  forwarded rs2.
- branch  input  1  conditional branch.
- funct3  input  3  branch condition.
- jal  input  1  jump and link.
- jalr  input  1  jump and link register.
- hazard  input  1  decode stalled.
- bht_flush  input  1  synchronous clear of all counters to BHT_INIT.
- branch_taken  output  1  resolved taken (combinational).
- mispredict  output  1  redirect or flush required (combinational).
- illegal_br  output  1  branch with reserved funct3 010 or 011.
- br_cnt  output  CNT_W  count of resolved conditional branches.
- mispred_cnt  output  CNT_W  count of mispredicts.

Behaviour:
- act = d_valid & !hazard. When act=0, branch_taken, mispredict and illegal_br are 0 and no state changes.
- Conditions, with XLEN-wide compares:
  - 000 beq: equal.
  - 001 bne: not equal.
  - 100 blt: signed less-than.
  - 101 bge: signed not less-than.
  - 110 bltu: unsigned less-than.
  - 111 bgeu: unsigned not less-than.
  - 010 / 011 are reserved: taken=0, illegal_br=1, and no BHT or counter update.
- branch_taken = act & ((branch & cond) | jal | jalr).
- mispredict:
  - Legal branch: branch_taken != d_pred_taken.
  - jal: !d_pred_taken.
  - jalr: always 1, because the target is never predicted.
- Precedence when more than one of branch, jal, jalr is asserted: jalr > jal > branch. The bench never drives this, but the RTL must be deterministic.
- BHT update, at the next rising edge when act & branch & legal funct3:
  - Counter at idx(d_pc) increments when taken, saturating at 3.
  - Decrements when not taken, saturating at 0.
  - Only one counter is written per cycle.
- Read/write collision: if idx(f_pc) == idx(d_pc) in an update cycle, f_pred_taken shows the pre-update value. There is no bypass.
- bht_flush: all counters take BHT_INIT at the edge. A flush beats a coincident update. Performance counters are not affected.
- Performance counters:
  - br_cnt increments on each BHT-update condition.
  - mispred_cnt increments when act & mispredict, including jal and jalr.
  - Both wrap modulo 2^CNT_W.
- Reset (rst_n low, asynchronous): all counters = BHT_INIT, br_cnt = 0, mispred_cnt = 0. Comb outputs follow inputs.
  - f_pred_taken = BHT_INIT[1] during reset.
  - Reset during an update cycle wins; no partial write.
- Latency:
  - Resolution: 0 cycles.
  - BHT training visible to fetch 1 cycle after resolution.
  - Counters visible 1 cycle after the event.
- No internal FSM beyond the counters. Each entry is a 4-state saturating machine: SNT(0), WNT(1), WT(2), ST(3). Predict taken when the counter is in WT or ST.

Decomposition:
- Package branch_pkg:
  - funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - typedef bht_ctr_t (2-bit) and its enum values SNT, WNT, WT, ST.
  - Function sat_update(ctr, taken).
- Sub-module branch_cond_eval: combinational XLEN compare plus funct3 decode, producing cond and illegal_br.
- Top level holds the BHT array, update and flush logic, and performance counters.

Test Plan:
- Reset, then read any f_pc -> f_pred_taken=0, br_cnt=0, mispred_cnt=0.
- blt with rs1=32'hFFFF_FFFF, rs2=1, d_pred_taken=0 -> branch_taken=1, mispredict=1. Then bltu with the same operands -> taken=0.
- Resolve 3 taken branches at d_pc=0x100 -> counter goes WNT→WT→ST→ST. f_pred_taken(0x100)=1 from the cycle after the first update. br_cnt=3.
- Alias check: d_pc=0x100 and f_pc=0x200 (same index for 64 entries) in the update cycle -> old prediction shown; new value the next cycle.
- hazard=1 with a taken beq (rs1=rs2=5) -> all outputs 0, no counter change. funct3=010 -> illegal_br=1, no update.
- bht_flush together with an update -> all entries read BHT_INIT. jalr with d_pred_taken=1 -> mispredict=1 and mispred_cnt increments. Preload mispred_cnt to 2^CNT_W−1 -> wraps to 0.
